// File: rtl/eth_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_framer_pkg
//  Description : Shared definitions for the GMII transmit framer: framer
//                state encoding, preamble/SFD byte values, field lengths and
//                the FCS byte extraction helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package eth_tx_framer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    PAD      = 3'd4,
    FCS      = 3'd5,
    IFG      = 3'd6
  } tx_state_e;

  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD      = 8'hD5;
  localparam int         PREAMBLE_LEN = 7;
  localparam int         FCS_LEN      = 4;

  // FCS byte k (0 = first on the wire) from the CRC engine state.
  // The engine keeps its register MSB-first, so each wire byte is an
  // inverted, bit-reversed slice: txd[7-i] = ~crc[24-8k+i].
  // For a 2-bit k, 3-k equals ~k, which selects slice [31:24] for k=0.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc,
                                          input logic [1:0]  k);
    logic [7:0] w_slice;
    logic [7:0] w_byte;
    w_slice = crc[{~k, 3'b000} +: 8];
    w_byte  = '0;
    for (int i = 0; i < 8; i++) begin
      w_byte[7-i] = ~w_slice[i];
    end
    return w_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_framer
//  Description : GMII transmit framer. Wraps a body byte stream with
//                preamble/SFD, zero-pads short frames, appends the FCS read
//                back from an external 8-bit CRC32 engine and enforces the
//                inter-frame gap. Aborts a frame with tx_er on underrun.
//  Ports       : clk, rst            clock, async active-high reset
//                s_data/s_valid/s_last/s_ready   body byte stream in
//                crc_data_in/crc_en/crc_clr      drive to CRC engine
//                crc_data                        CRC engine state (read)
//                gmii_txd/gmii_tx_en/gmii_tx_er  GMII transmit (registered)
//                tx_busy/tx_done/tx_underrun     status
//  Revision    : 1.0  initial release
// ============================================================================
module eth_tx_framer
  import eth_tx_framer_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG_LEN   = 12,
  parameter int CNT_W     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  crc_data_in,
  output logic        crc_en,
  output logic        crc_clr,
  input  logic [31:0] crc_data,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_underrun
);

  // Sequencing counter for preamble, FCS and IFG; IFG_LEN must fit in it.
  localparam int                 SUB_W      = 8;
  localparam logic [SUB_W-1:0]   c_pre_last = SUB_W'(PREAMBLE_LEN - 1);
  localparam logic [SUB_W-1:0]   c_fcs_last = SUB_W'(FCS_LEN - 1);
  // The IDLE cycle that sees s_valid is itself one idle byte-time on the
  // wire, so IFG lasts IFG_LEN-1 cycles to give exactly IFG_LEN idle bytes.
  localparam logic [SUB_W-1:0]   c_ifg_last = SUB_W'(IFG_LEN - 2);
  localparam logic [CNT_W:0]     c_min      = (CNT_W+1)'(MIN_FRAME);

  tx_state_e         r_state;
  tx_state_e         w_next;
  tx_state_e         w_after_tx;
  logic [SUB_W-1:0]  r_sub;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W:0]    w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt_sat;

  // Extra bit keeps cnt+1 honest against MIN_FRAME even when saturated.
  assign w_cnt_inc  = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_cnt_sat  = (&r_cnt) ? r_cnt : w_cnt_inc[CNT_W-1:0];
  assign w_after_tx = (IFG_LEN > 1) ? IFG : IDLE;
  assign tx_busy    = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    s_ready     = 1'b0;
    crc_data_in = 8'h00;
    crc_en      = 1'b0;
    crc_clr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid) w_next = PREAMBLE;
      end
      PREAMBLE: begin
        crc_clr = 1'b1;
        if (r_sub == c_pre_last) w_next = SFD;
      end
      SFD: begin
        w_next = DATA;
      end
      DATA: begin
        s_ready     = 1'b1;
        crc_data_in = s_data;
        if (s_valid) begin
          crc_en = 1'b1;
          if (s_last) begin
            w_next = (w_cnt_inc < c_min) ? PAD : FCS;
          end
        end else begin
          w_next = w_after_tx;
        end
      end
      PAD: begin
        crc_en = 1'b1;
        if (w_cnt_inc >= c_min) w_next = FCS;
      end
      FCS: begin
        if (r_sub == c_fcs_last) w_next = w_after_tx;
      end
      IFG: begin
        if (r_sub == c_ifg_last) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // r_sub restarts on every state change; r_cnt tracks body+pad bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= '0;
      r_cnt <= '0;
    end else begin
      r_sub <= (w_next != r_state) ? '0 : r_sub + 1'b1;
      case (r_state)
        IDLE:    r_cnt <= '0;
        DATA:    r_cnt <= s_valid ? w_cnt_sat : '0;
        PAD:     r_cnt <= w_cnt_sat;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // GMII side is one register stage behind the state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
      case (r_state)
        PREAMBLE: begin
          gmii_txd   <= ETH_PREAMBLE;
          gmii_tx_en <= 1'b1;
        end
        SFD: begin
          gmii_txd   <= ETH_SFD;
          gmii_tx_en <= 1'b1;
        end
        DATA: begin
          gmii_tx_en <= 1'b1;
          if (s_valid) begin
            gmii_txd <= s_data;
          end else begin
            gmii_tx_er  <= 1'b1;
            tx_underrun <= 1'b1;
          end
        end
        PAD: begin
          gmii_tx_en <= 1'b1;
        end
        FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= fcs_byte(crc_data, r_sub[1:0]);
          tx_done    <= (r_sub == c_fcs_last);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
